// File: rtl/glitch_filter_pkg.sv
// Shared constants and helpers for the glitch_filter_multi block.
package glitch_filter_pkg;

  localparam int unsigned GF_DEF_FILTER_CYCLES = 5;
  localparam int unsigned GF_DEF_SYNC_STAGES   = 2;

  // Ceiling log2; gf_clog2(0) and gf_clog2(1) both return 0.
  function automatic int unsigned gf_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (v > (32'd1 << i)) r = 32'(i + 1);
    end
    return r;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned gf_cnt_width(input int unsigned n);
    int unsigned w;
    w = gf_clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/glitch_filter_chan.sv
// One glitch filter channel: synchroniser, consecutive-sample counter,
// registered filtered level and one-cycle rise/fall pulses.
module glitch_filter_chan
  import glitch_filter_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES = GF_DEF_FILTER_CYCLES,
  parameter int unsigned SYNC_STAGES   = GF_DEF_SYNC_STAGES,
  parameter logic        RESET_BIT     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall
);

  localparam int unsigned   CW       = gf_cnt_width(FILTER_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   out_d, rise_d, fall_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Plain flop chain, no logic between stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {SYNC_STAGES{RESET_BIT}};
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], in};
  end

  // Any sample agreeing with out restarts the count.
  always_comb begin
    cnt_d  = cnt_q;
    out_d  = out;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s == out) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      out_d  = s;
      rise_d = s;
      fall_d = ~s;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      out   <= RESET_BIT;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out   <= out_d;
      rise  <= rise_d;
      fall  <= fall_d;
    end
  end

endmodule

// File: rtl/glitch_filter_multi.sv
// Multi-channel glitch filter / debouncer. Define GLITCH_FILTER_IRQ_EN to
// add sticky per-channel event flags (write-1-to-clear) and an irq output.
module glitch_filter_multi
  import glitch_filter_pkg::*;
#(
  parameter int unsigned          CHANNELS      = 4,
  parameter int unsigned          FILTER_CYCLES = GF_DEF_FILTER_CYCLES,
  parameter int unsigned          SYNC_STAGES   = GF_DEF_SYNC_STAGES,
  parameter logic [CHANNELS-1:0]  RESET_VAL     = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] in,
`ifdef GLITCH_FILTER_IRQ_EN
  input  logic [CHANNELS-1:0] evt_clr,
  output logic [CHANNELS-1:0] evt,
  output logic                irq,
`endif
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    glitch_filter_chan #(
      .FILTER_CYCLES (FILTER_CYCLES),
      .SYNC_STAGES   (SYNC_STAGES),
      .RESET_BIT     (RESET_VAL[i])
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .in    (in[i]),
      .out   (out[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

`ifdef GLITCH_FILTER_IRQ_EN
  logic [CHANNELS-1:0] evt_d;

  // Set has priority over a simultaneous clear.
  always_comb begin
    evt_d = (evt & ~evt_clr) | rise | fall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) evt <= '0;
    else        evt <= evt_d;
  end

  assign irq = |evt;
`endif

endmodule

// File: tb/tb_glitch_filter_multi.sv
// Directed self-checking bench for glitch_filter_multi: default instance plus
// a FILTER_CYCLES=1 / SYNC_STAGES=3 / RESET_VAL=4'hA instance.
module tb_glitch_filter_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_a, out_a, rise_a, fall_a;
  logic [3:0] in_b, out_b, rise_b, fall_b;
  int         checks = 0;
  int         failures = 0;
`ifdef GLITCH_FILTER_IRQ_EN
  logic [3:0] evt_clr_a, evt_a, evt_clr_b, evt_b;
  logic       irq_a, irq_b;
`endif

  always #5 clk = ~clk;

  glitch_filter_multi u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in_a),
`ifdef GLITCH_FILTER_IRQ_EN
    .evt_clr (evt_clr_a),
    .evt     (evt_a),
    .irq     (irq_a),
`endif
    .out   (out_a),
    .rise  (rise_a),
    .fall  (fall_a)
  );

  glitch_filter_multi #(
    .CHANNELS      (4),
    .FILTER_CYCLES (1),
    .SYNC_STAGES   (3),
    .RESET_VAL     (4'hA)
  ) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in_b),
`ifdef GLITCH_FILTER_IRQ_EN
    .evt_clr (evt_clr_b),
    .evt     (evt_b),
    .irq     (irq_b),
`endif
    .out   (out_b),
    .rise  (rise_b),
    .fall  (fall_b)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [8:0] chatter;
    chatter = 9'b1_1111_0111; // applied LSB first: 1,1,1,0,1,1,1,1,1
    rst_n = 1'b0;
    in_a  = 4'h0;
    in_b  = 4'hA;
`ifdef GLITCH_FILTER_IRQ_EN
    evt_clr_a = 4'h0;
    evt_clr_b = 4'h0;
`endif
    tick(3);
    chk("reset_out_a", out_a, 4'h0);
    chk("reset_rise_a", rise_a, 4'h0);
    chk("reset_fall_a", fall_a, 4'h0);
    chk("reset_out_b", out_b, 4'hA);
    rst_n = 1'b1;
    tick(2);
    chk("idle_out_a", out_a, 4'h0);
    chk("idle_out_b", out_b, 4'hA);

    // Params instance: a step reaches out on the 4th edge.
    in_b = 4'h5;
    tick(3);
    chk("b_step_e3", out_b, 4'hA);
    tick(1);
    chk("b_step_e4", out_b, 4'h5);
    chk("b_rise_e4", rise_b, 4'h5);
    chk("b_fall_e4", fall_b, 4'hA);
    tick(1);
    chk("b_rise_e5", rise_b, 4'h0);
    chk("b_fall_e5", fall_b, 4'h0);

    // 4-sample pulse on ch0 is rejected.
    in_a = 4'h1;
    tick(4);
    in_a = 4'h0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      chk("glitch4_rise", rise_a, 4'h0);
    end
    chk("glitch4_out", out_a, 4'h0);

    // 5-sample pulse on ch0 is accepted at edge 7.
    in_a = 4'h1;
    tick(5);
    in_a = 4'h0;
    tick(1);
    chk("pulse5_e6", out_a, 4'h0);
    tick(1);
    chk("pulse5_e7_out", out_a, 4'h1);
    chk("pulse5_e7_rise", rise_a, 4'h1);
    tick(1);
    chk("pulse5_e8_rise", rise_a, 4'h0);
    tick(3);
    chk("pulse5_e11", out_a, 4'h1);
    tick(1);
    chk("pulse5_e12_out", out_a, 4'h0);
    chk("pulse5_e12_fall", fall_a, 4'h1);
    tick(4);

    // Chatter on ch1: the 0 sample restarts the count.
    for (int k = 0; k < 9; k++) begin
      in_a[1] = chatter[k];
      tick(1);
      chk("chatter_hold", out_a, 4'h0);
    end
    tick(1);
    chk("chatter_e10", out_a, 4'h0);
    tick(1);
    chk("chatter_e11_out", out_a, 4'h2);
    chk("chatter_e11_rise", rise_a, 4'h2);

    // Independence: ch3 up first, then ch2 rises while ch3 falls.
    in_a = 4'hA;
    tick(7);
    chk("ch3_up_out", out_a, 4'hA);
    chk("ch3_up_rise", rise_a, 4'h8);
    in_a = 4'h6;
    tick(6);
    chk("indep_e6_out", out_a, 4'hA);
    chk("indep_e6_fall", fall_a, 4'h0);
    tick(1);
    chk("indep_e7_out", out_a, 4'h6);
    chk("indep_e7_rise", rise_a, 4'h4);
    chk("indep_e7_fall", fall_a, 4'h8);
    tick(1);
    chk("indep_e8_rise", rise_a, 4'h0);
    chk("indep_e8_fall", fall_a, 4'h0);

    // Reset mid-count with all inputs high.
    in_a = 4'hF;
    tick(4);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_a", out_a, 4'h0);
    chk("async_rst_rise_a", rise_a, 4'h0);
    chk("async_rst_fall_a", fall_a, 4'h0);
    chk("async_rst_out_b", out_b, 4'hA);
    tick(2);
    rst_n = 1'b1;
    tick(6);
    chk("rel_e6_out", out_a, 4'h0);
    chk("rel_e6_rise", rise_a, 4'h0);
    tick(1);
    chk("rel_e7_out", out_a, 4'hF);
    chk("rel_e7_rise", rise_a, 4'hF);
    tick(1);
    chk("rel_e8_rise", rise_a, 4'h0);

`ifdef GLITCH_FILTER_IRQ_EN
    evt_clr_a = 4'hF;
    tick(1);
    evt_clr_a = 4'h0;
    chk("evt_cleared", evt_a, 4'h0);
    in_a = 4'h7;
    tick(7);
    chk("irq_fall", fall_a, 4'h8);
    tick(1);
    chk("irq_evt_set", evt_a, 4'h8);
    chk("irq_set", {3'b0, irq_a}, 4'h1);
    in_a = 4'hF;
    tick(7);
    chk("irq_rise", rise_a, 4'h8);
    evt_clr_a = 4'h8;
    tick(1);
    chk("irq_set_wins", evt_a, 4'h8);
    tick(1);
    evt_clr_a = 4'h0;
    chk("irq_clr_evt", evt_a, 4'h0);
    chk("irq_clr_irq", {3'b0, irq_a}, 4'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
